// File: rtl/dtcctf_trg_decoder.sv
// dtcctf_trg_decoder: synchronises the DTC trigger/clock lines, classifies trigger pulses by width and monitors the DTC clock
module dtcctf_trg_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int TRG_MIN_W   = 2,
  parameter int TRG_MAX_W   = 8,
  parameter int RST_MIN_W   = 32,
  parameter int DEADTIME    = 16,
  parameter int CLK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dtc_trg,
  input  logic        dtc_clk,
  input  logic        enable,
  output logic        trg_out,
  output logic        resync_out,
  output logic        busy,
  output logic [31:0] trg_cnt,
  output logic [15:0] bad_cnt,
  output logic        clk_ok
);
  localparam int WW = $clog2(RST_MIN_W + 1);
  localparam int DW = $clog2(DEADTIME + 1);
  localparam int TW = $clog2(CLK_TIMEOUT + 1);
  localparam logic [WW-1:0] W_SAT  = WW'(RST_MIN_W);
  localparam logic [WW-1:0] W_MIN  = WW'(TRG_MIN_W);
  localparam logic [WW-1:0] W_MAX  = WW'(TRG_MAX_W);
  localparam logic [DW-1:0] D_INIT = DW'(DEADTIME);
  localparam logic [TW-1:0] T_MAX  = TW'(CLK_TIMEOUT);
  typedef enum logic [1:0] {IDLE, HIGH, DEAD} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] trg_sync, clk_sync;
  logic s_trg, s_trg_d, s_clk, clk_edge;
  logic [WW-1:0] w, w_n;
  logic [DW-1:0] dead, dead_n;
  logic [TW-1:0] tcnt;
  logic trg_n, resync_n, bad_n;
  assign s_trg = trg_sync[SYNC_STAGES-1];
  assign s_clk = clk_sync[SYNC_STAGES-1];
  // the clock monitor reacts on the same edge that changes s_clk
  assign clk_edge = clk_sync[SYNC_STAGES-2] != s_clk;
  always_comb begin
    state_n  = state;
    w_n      = w;
    dead_n   = dead;
    trg_n    = 1'b0;
    resync_n = 1'b0;
    bad_n    = 1'b0;
    if (!enable)
      state_n = IDLE;
    else
      unique case (state)
        IDLE: if (s_trg && !s_trg_d) begin
          state_n = HIGH;
          w_n     = WW'(1);
        end
        HIGH: if (s_trg)
          w_n = (w == W_SAT) ? w : w + 1'b1;
        else begin
          state_n = IDLE;
          if (w >= W_SAT)
            resync_n = 1'b1;
          else if (w >= W_MIN && w <= W_MAX) begin
            trg_n   = 1'b1;
            state_n = DEAD;
            dead_n  = D_INIT;
          end else
            bad_n = 1'b1;
        end
        DEAD: begin
          dead_n  = (dead == '0) ? dead : dead - 1'b1;
          state_n = (dead == '0 && !s_trg) ? IDLE : DEAD;
        end
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      trg_sync   <= '0;
      clk_sync   <= '0;
      s_trg_d    <= 1'b0;
      state      <= IDLE;
      w          <= '0;
      dead       <= '0;
      busy       <= 1'b0;
      trg_out    <= 1'b0;
      resync_out <= 1'b0;
      trg_cnt    <= '0;
      bad_cnt    <= '0;
    end else begin
      trg_sync   <= {trg_sync[SYNC_STAGES-2:0], dtc_trg};
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], dtc_clk};
      s_trg_d    <= s_trg;
      state      <= state_n;
      w          <= w_n;
      dead       <= dead_n;
      busy       <= state_n != IDLE;
      trg_out    <= trg_n;
      resync_out <= resync_n;
      trg_cnt    <= resync_n ? '0 : trg_cnt + 32'(trg_n);
      if (bad_n && bad_cnt != 16'hFFFF)
        bad_cnt <= bad_cnt + 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tcnt   <= '0;
      clk_ok <= 1'b0;
    end else if (clk_edge) begin
      tcnt   <= '0;
      clk_ok <= 1'b1;
    end else if (tcnt != T_MAX) begin
      tcnt <= tcnt + 1'b1;
      if (tcnt == T_MAX - 1'b1)
        clk_ok <= 1'b0;
    end
endmodule
